bht_update_queue: RTL and testbench
===================================

BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CVA6Cfg, config_pkg::cva6_cfg_empty, supplies VLEN.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- GHR_BITS, 8, committed global-history width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, synchronous active-high reset.
- flush_bp_i, in, 1, drop all queued updates and clear history.
- debug_mode_i, in, 1, CSR debug state.
- res_valid_i, in, 1, execute presents a resolved branch.
- res_ready_o, out, 1, queue can accept.
- res_pc_i, in, VLEN, branch PC.
- res_cond_i, in, 1, conditional branch.
- res_taken_i, in, 1, actual outcome.
- res_pred_taken_i, in, 1, frontend prediction.
- upd_valid_o, out, 1, update to the predictor.
- upd_ready_i, in, 1, predictor accepts.
- upd_pc_o, out, VLEN, update PC.
- upd_taken_o, out, 1, update outcome.
- mispredict_o, out, 1, one-cycle mispredict pulse.
- ghr_o, out, GHR_BITS, committed global history.
- perf_upd_o, out, 32, issued-update count.
- perf_mis_o, out, 32, mispredict count.

Function
REQ-003 A transfer on the input side SHALL occur when res_valid_i and res_ready_o are both high; res_ready_o SHALL equal !full, with no same-cycle bypass when full.
REQ-004 An accepted entry with res_cond_i=0 SHALL be consumed without being enqueued and without affecting mispredict_o or ghr_o.
REQ-005 An accepted conditional entry SHALL be written into the FIFO as {pc, taken}; upd_valid_o for it SHALL rise no earlier than the next cycle, giving a minimum latency of 1.
REQ-006 upd_valid_o SHALL equal !empty; upd_pc_o and upd_taken_o SHALL reflect the head entry and SHALL hold stable while upd_valid_o=1 and upd_ready_i=0.
REQ-007 The head SHALL pop when upd_valid_o and upd_ready_i are both high; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-008 While debug_mode_i=1, accepted entries SHALL be dropped rather than enqueued; entries already queued SHALL still drain normally.
REQ-009 On each pop, ghr_o SHALL update next cycle to {ghr_o[GHR_BITS-2:0], upd_taken_o}, shifting left and inserting the outcome at the LSB.
REQ-010 mispredict_o SHALL pulse high the cycle after an accepted conditional entry with res_taken_i != res_pred_taken_i; the debug-mode drop SHALL NOT suppress it.
REQ-011 Pointers SHALL be log2(DEPTH) bits plus one wrap bit:
- full SHALL mean the indices are equal and the wrap bits differ.
- empty SHALL mean both pointers are equal.
REQ-012 flush_bp_i SHALL empty the FIFO and zero ghr_o next cycle; a push or pop in the same cycle SHALL be ignored, so flush wins.
REQ-013 While flush_bp_i=1, mispredict_o SHALL be 0 on the following cycle.

Reset
REQ-014 With rst_i=1 at a clock edge, the following SHALL be true after that edge:
- pointers are 0 and the FIFO is empty.
- upd_valid_o=0, res_ready_o=1, mispredict_o=0.
- ghr_o=0 and both perf counters are 0.
REQ-015 Reset asserted mid-operation SHALL discard all queued entries; FIFO storage need not be cleared.

Configuration
REQ-016 With BP_UPDQ_PERF_CNT_EN defined:
- perf_upd_o SHALL increment on each pop.
- perf_mis_o SHALL increment on each mispredict_o pulse.
- both SHALL saturate at 32'hFFFF_FFFF.
- flush_bp_i SHALL NOT clear them.
REQ-017 Without BP_UPDQ_PERF_CNT_EN, perf_upd_o and perf_mis_o SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-018 The update entry typedef {pc, taken} and the default GHR width constant SHALL live in ariane_pkg.
REQ-019 Storage and pointer logic SHALL be one sub-module, bp_upd_fifo, parameterised by DEPTH and entry type; history, mispredict, and perf logic SHALL stay in the top level.

Verification
REQ-020 Reset, then push conditional {pc=0x8000_0010, taken=1} with upd_ready_i=1 -> upd_valid_o=1 the next cycle with the same pc/taken; ghr_o=0x01 the cycle after the pop.
REQ-021 Hold upd_ready_i=0 and push 4 entries with DEPTH=4 -> res_ready_o=0 after the 4th; a 5th res_valid_i is not accepted; raising upd_ready_i drains all 4 in order, one per cycle.
REQ-022 Push with res_taken_i=0 and res_pred_taken_i=1 -> mispredict_o=1 for exactly one cycle; with BP_UPDQ_PERF_CNT_EN, perf_mis_o=1.
REQ-023 Set debug_mode_i=1 with 2 entries queued, then push 1 more -> exactly 2 updates are issued and the new one is dropped.
REQ-024 Assert flush_bp_i with 3 queued, ghr_o=0xA5, and a push in the same cycle -> next cycle upd_valid_o=0, ghr_o=0x00, and the FIFO is empty.
REQ-025 Push a non-conditional entry (res_cond_i=0) -> it is accepted, upd_valid_o stays 0, and ghr_o is unchanged.

Source files
------------

// File: rtl/ariane_pkg.sv
// ariane_pkg: branch-predictor update entry and default committed-history width.
package ariane_pkg;

    // Entry PC is stored at the widest supported VLEN; narrower cores zero-extend.
    localparam int unsigned BP_PC_W          = 64;
    localparam int unsigned GHR_BITS_DEFAULT = 8;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
    } bp_upd_entry_t;

endpackage

// File: rtl/config_pkg.sv
// config_pkg: minimal CVA6 configuration record; only VLEN is consumed here.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd64};

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: power-of-two FIFO with wrap-bit pointers; flush and reset empty it.
module bp_upd_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t data_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = data_i;
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers resolved conditional branches toward the BHT, tracks committed history.
// Define BP_UPDQ_PERF_CNT_EN to build saturating update/mispredict performance counters.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH    = 4,
    parameter int unsigned           GHR_BITS = GHR_BITS_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_bp_i,
    input  logic                    debug_mode_i,
    input  logic                    res_valid_i,
    output logic                    res_ready_o,
    input  logic [CVA6Cfg.VLEN-1:0] res_pc_i,
    input  logic                    res_cond_i,
    input  logic                    res_taken_i,
    input  logic                    res_pred_taken_i,
    output logic                    upd_valid_o,
    input  logic                    upd_ready_i,
    output logic [CVA6Cfg.VLEN-1:0] upd_pc_o,
    output logic                    upd_taken_o,
    output logic                    mispredict_o,
    output logic [GHR_BITS-1:0]     ghr_o,
    output logic [31:0]             perf_upd_o,
    output logic [31:0]             perf_mis_o
);

    bp_upd_entry_t       res_entry, head;
    logic                full, empty, accept, push, pop;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                mis_q, mis_d;

    assign res_ready_o  = !full;
    assign accept       = res_valid_i && res_ready_o;
    assign push         = accept && res_cond_i && !debug_mode_i && !flush_bp_i;
    assign pop          = upd_valid_o && upd_ready_i && !flush_bp_i;
    assign upd_valid_o  = !empty;
    assign upd_pc_o     = head.pc[CVA6Cfg.VLEN-1:0];
    assign upd_taken_o  = head.taken;
    assign mispredict_o = mis_q;
    assign ghr_o        = ghr_q;
    assign res_entry    = '{pc: BP_PC_W'(res_pc_i), taken: res_taken_i};

    bp_upd_fifo #(
        .DEPTH  (DEPTH),
        .entry_t(bp_upd_entry_t)
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_bp_i),
        .push_i (push),
        .pop_i  (pop),
        .data_i (res_entry),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    // Mispredicts are flagged at acceptance, so debug-mode drops still report them.
    always_comb begin
        ghr_d = flush_bp_i ? '0 : pop ? {ghr_q[GHR_BITS-2:0], head.taken} : ghr_q;
        mis_d = accept && res_cond_i && (res_taken_i != res_pred_taken_i) && !flush_bp_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
            mis_q <= 1'b0;
        end else begin
            ghr_q <= ghr_d;
            mis_q <= mis_d;
        end
    end

`ifdef BP_UPDQ_PERF_CNT_EN
    logic [31:0] perf_upd_q, perf_upd_d, perf_mis_q, perf_mis_d;

    always_comb begin
        perf_upd_d = (pop && !(&perf_upd_q)) ? perf_upd_q + 32'd1 : perf_upd_q;
        perf_mis_d = (mis_q && !(&perf_mis_q)) ? perf_mis_q + 32'd1 : perf_mis_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_upd_o = perf_upd_q;
    assign perf_mis_o = perf_mis_q;
`else
    assign perf_upd_o = '0;
    assign perf_mis_o = '0;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: vector table plus hand sequences, with a scoreboard for issued updates.
module tb_bht_update_queue;

    logic        clk = 1'b0;
    logic        rst_i, flush_bp_i, debug_mode_i, res_valid_i, res_ready_o;
    logic [63:0] res_pc_i, upd_pc_o;
    logic        res_cond_i, res_taken_i, res_pred_taken_i;
    logic        upd_valid_o, upd_ready_i, upd_taken_o, mispredict_o;
    logic [7:0]  ghr_o;
    logic [31:0] perf_upd_o, perf_mis_o;

    always #5 clk = ~clk;

    bht_update_queue #(
        .DEPTH   (4),
        .GHR_BITS(8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_bp_i      (flush_bp_i),
        .debug_mode_i    (debug_mode_i),
        .res_valid_i     (res_valid_i),
        .res_ready_o     (res_ready_o),
        .res_pc_i        (res_pc_i),
        .res_cond_i      (res_cond_i),
        .res_taken_i     (res_taken_i),
        .res_pred_taken_i(res_pred_taken_i),
        .upd_valid_o     (upd_valid_o),
        .upd_ready_i     (upd_ready_i),
        .upd_pc_o        (upd_pc_o),
        .upd_taken_o     (upd_taken_o),
        .mispredict_o    (mispredict_o),
        .ghr_o           (ghr_o),
        .perf_upd_o      (perf_upd_o),
        .perf_mis_o      (perf_mis_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        c, t, p, r, d, f;
        logic        e_rdy, e_vld, e_mis;
        logic [7:0]  e_ghr;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic perf_chk(input logic [31:0] e_upd, input logic [31:0] e_mis);
`ifdef BP_UPDQ_PERF_CNT_EN
        chk("perf_upd", perf_upd_o, e_upd);
        chk("perf_mis", perf_mis_o, e_mis);
`else
        chk("perf_upd_tied", perf_upd_o, 0);
        chk("perf_mis_tied", perf_mis_o, 0);
`endif
    endtask

    // Inputs are applied for one clock edge; outputs are sampled on the preceding negedge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic c, input logic t,
                       input logic p, input logic r, input logic d, input logic f,
                       input logic e_rdy, input logic e_vld, input logic e_mis,
                       input logic [7:0] e_ghr);
        @(posedge clk);
        #1;
        res_valid_i      = v;
        res_pc_i         = {32'h0, pc};
        res_cond_i       = c;
        res_taken_i      = t;
        res_pred_taken_i = p;
        upd_ready_i      = r;
        debug_mode_i     = d;
        flush_bp_i       = f;
        @(negedge clk);
        chk("res_ready", res_ready_o, e_rdy);
        chk("upd_valid", upd_valid_o, e_vld);
        chk("mispredict", mispredict_o, e_mis);
        chk("ghr", ghr_o, e_ghr);
        if (upd_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_update actual=%0h required=none", upd_pc_o);
            end else begin
                chk("upd_pc", upd_pc_o, {32'h0, sb[0].pc});
                chk("upd_taken", upd_taken_o, sb[0].taken);
                if (upd_ready_i && !f) void'(sb.pop_front());
            end
        end
        if (v && e_rdy && c && !d && !f) sb.push_back('{pc, t});
        if (f) sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //          v     pc            c     t     p     r     d     f     rdy   vld   mis   ghr
        tbl[0]  = '{1'b1, 32'h8000_0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[3]  = '{1'b1, 32'h8000_0020, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};
        tbl[6]  = '{1'b1, 32'h8000_0024, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02};
        tbl[8]  = '{1'b1, 32'h8000_0030, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02};
        tbl[9]  = '{1'b1, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0A};

        rst_i = 1'b1; flush_bp_i = 1'b0; debug_mode_i = 1'b0; res_valid_i = 1'b0;
        res_pc_i = '0; res_cond_i = 1'b0; res_taken_i = 1'b0; res_pred_taken_i = 1'b0;
        upd_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", res_ready_o, 1);
        chk("rst_valid", upd_valid_o, 0);
        chk("rst_mis", mispredict_o, 0);
        chk("rst_ghr", ghr_o, 0);
        perf_chk(0, 0);

        foreach (tbl[i])
            cyc(tbl[i].v, tbl[i].pc, tbl[i].c, tbl[i].t, tbl[i].p, tbl[i].r, tbl[i].d, tbl[i].f,
                tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_mis, tbl[i].e_ghr);
        perf_chk(4, 1);

        // Fill to full with the consumer stalled, try a fifth, then drain in order.
        cyc(1, 32'h100, 1, 1, 1, 0, 0, 0, 1, 0, 0, 8'h0A);
        cyc(1, 32'h104, 1, 0, 0, 0, 0, 0, 1, 1, 0, 8'h0A);
        cyc(1, 32'h108, 1, 1, 1, 0, 0, 0, 1, 1, 0, 8'h0A);
        cyc(1, 32'h10C, 1, 1, 1, 0, 0, 0, 1, 1, 0, 8'h0A);
        cyc(1, 32'h110, 1, 0, 0, 0, 0, 0, 0, 1, 0, 8'h0A);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h0A);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 1, 0, 8'h15);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 1, 0, 8'h2A);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 1, 0, 8'h55);
        cyc(0, 32'h0,   0, 0, 0, 0, 0, 0, 1, 0, 0, 8'hAB);

        // Debug mode drops the new entry but still flags its mispredict.
        cyc(1, 32'h200, 1, 1, 1, 0, 0, 0, 1, 0, 0, 8'hAB);
        cyc(1, 32'h204, 1, 0, 0, 0, 0, 0, 1, 1, 0, 8'hAB);
        cyc(1, 32'h208, 1, 1, 0, 0, 1, 0, 1, 1, 0, 8'hAB);
        cyc(0, 32'h0,   0, 0, 0, 1, 1, 0, 1, 1, 1, 8'hAB);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 1, 0, 8'h57);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 0, 0, 8'hAE);

        // Stream eight outcomes through to leave history at 0xA5.
        cyc(1, 32'h300, 1, 1, 1, 1, 0, 0, 1, 0, 0, 8'hAE);
        cyc(1, 32'h304, 1, 0, 0, 1, 0, 0, 1, 1, 0, 8'hAE);
        cyc(1, 32'h308, 1, 1, 1, 1, 0, 0, 1, 1, 0, 8'h5D);
        cyc(1, 32'h30C, 1, 0, 0, 1, 0, 0, 1, 1, 0, 8'hBA);
        cyc(1, 32'h310, 1, 0, 0, 1, 0, 0, 1, 1, 0, 8'h75);
        cyc(1, 32'h314, 1, 1, 1, 1, 0, 0, 1, 1, 0, 8'hEA);
        cyc(1, 32'h318, 1, 0, 0, 1, 0, 0, 1, 1, 0, 8'hD4);
        cyc(1, 32'h31C, 1, 1, 1, 1, 0, 0, 1, 1, 0, 8'hA9);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 1, 0, 8'h52);

        // Three queued, then flush with a simultaneous push, pop and would-be mispredict.
        cyc(1, 32'h500, 1, 1, 1, 0, 0, 0, 1, 0, 0, 8'hA5);
        cyc(1, 32'h504, 1, 1, 1, 0, 0, 0, 1, 1, 0, 8'hA5);
        cyc(1, 32'h508, 1, 1, 1, 0, 0, 0, 1, 1, 0, 8'hA5);
        cyc(1, 32'h50C, 1, 0, 1, 1, 0, 1, 1, 1, 0, 8'hA5);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
        cyc(0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00);

        // Reset mid-operation with an entry queued and non-zero history.
        cyc(1, 32'h400, 1, 1, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 32'h404, 1, 1, 1, 1, 0, 0, 1, 1, 0, 8'h00);
        perf_chk(18, 2);
        @(posedge clk);
        #1;
        rst_i = 1'b1; res_valid_i = 1'b0; upd_ready_i = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b0;
        sb.delete();
        cyc(0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
        perf_chk(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
